rgmii_tx_mspd: RTL



---
 rtl/eth_pkg.sv | 22 ++
 rtl/rgmii_oddr_lane.sv | 34 +++
 rtl/rgmii_tx_mspd.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared speed, state and idle encodings for the RGMII transmit path
package eth_pkg;

    // Link speed encodings; 2'b11 is treated as gigabit
    localparam logic [1:0] SPD_1000 = 2'b10;
    localparam logic [1:0] SPD_100  = 2'b01;
    localparam logic [1:0] SPD_10   = 2'b00;

    // Transmit FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_IFG  = 2'd2;

    // Nibble driven on TXD when no frame is in flight
    localparam logic [3:0] RGMII_IDLE = 4'h0;

    // Anything other than an explicit 10/100 code runs at gigabit
    function automatic logic is_gig(input logic [1:0] spd);
        return !((spd == SPD_100) || (spd == SPD_10));
    endfunction

endpackage

// File: rtl/rgmii_oddr_lane.sv
// rtl/rgmii_oddr_lane.sv - one ODDR2 output lane (C0 alignment, async reset)
//
// Ports:
//   clk   - transmit clock; both D inputs are captured on its rising edge
//   rst_n - asynchronous active-low reset (drives the ODDR2 R pin inverted)
//   d0    - value driven while clk is high
//   d1    - value driven while clk is low
//   q     - DDR pin output
module rgmii_oddr_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic d0,
    input  logic d1,
    output logic q
);

    logic d0_q;
    logic d1_q;

    // With C0 alignment both halves are captured on the rising edge, so the
    // falling-edge half is simply the second register presented while clk is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0_q <= 1'b0;
            d1_q <= 1'b0;
        end else begin
            d0_q <= d0;
            d1_q <= d1;
        end
    end

    assign q = clk ? d0_q : d1_q;

endmodule

// File: rtl/rgmii_tx_mspd.sv
// rtl/rgmii_tx_mspd.sv - multi-speed byte-stream to RGMII transmitter
//
// Ports:
//   gmii_tx_clk  - TX clock (125 / 25 / 2.5 MHz)
//   rst_n        - asynchronous active-low reset
//   speed        - 10: 1000, 01: 100, 00: 10, 11: 1000; sampled only while idle
//   tx_valid     - byte offered; contiguous valid bytes form one frame
//   tx_data      - offered byte
//   tx_er        - error flag for the offered byte
//   tx_ready     - byte accepted when tx_valid && tx_ready
//   tx_busy      - a frame or its inter-frame gap is in progress
//   frame_cnt    - frames completed (wraps)
//   err_cnt      - frames that carried at least one errored byte (wraps)
//   rgmii_txc    - forwarded TX clock
//   rgmii_tx_ctl - TX_CTL pin (TX_EN rising, TX_EN^TX_ER falling)
//   rgmii_txd    - TXD pins
module rgmii_tx_mspd
    import eth_pkg::*;
#(
    parameter int IFG_BYTES = 12,
    parameter int CNT_W     = 16,
    parameter int TXC_ODDR  = 1
) (
    input  logic             gmii_tx_clk,
    input  logic             rst_n,
    input  logic [1:0]       speed,
    input  logic             tx_valid,
    input  logic [7:0]       tx_data,
    input  logic             tx_er,
    output logic             tx_ready,
    output logic             tx_busy,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             rgmii_txc,
    output logic             rgmii_tx_ctl,
    output logic [3:0]       rgmii_txd
);

    localparam int IFG_W = $clog2(2 * IFG_BYTES + 2);
    localparam logic [IFG_W-1:0] IFG_LD_1G   = IFG_W'((IFG_BYTES > 0) ? IFG_BYTES - 1 : 0);
    localparam logic [IFG_W-1:0] IFG_LD_SLOW = IFG_W'((IFG_BYTES > 0) ? 2 * IFG_BYTES - 1 : 0);

    logic [1:0]       state;
    logic [1:0]       spd_q;
    logic             phase;
    logic             ready_ok;
    logic [IFG_W-1:0] ifg_cnt;
    logic             frame_err;
    logic [3:0]       hi_q;
    logic             er_q;

    logic [3:0]       txd_d0;
    logic [3:0]       txd_d1;
    logic             ctl_d0;
    logic             ctl_d1;

    logic             gig;
    logic             accept;
    logic             eof;

    // While idle the live speed input governs the first byte; spd_q catches
    // the same value on that edge and stays frozen for the rest of the frame.
    assign gig = is_gig((state == ST_IDLE) ? speed : spd_q);

    // ready_ok keeps tx_ready low throughout reset and opens it one edge later
    assign tx_ready = ready_ok && ((state == ST_IDLE) ||
                                  ((state == ST_SEND) && (gig || !phase)));
    assign accept   = tx_valid && tx_ready;
    assign eof      = (state == ST_SEND) && tx_ready && !tx_valid;
    assign tx_busy  = (state != ST_IDLE);

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            spd_q     <= SPD_1000;
            phase     <= 1'b0;
            ready_ok  <= 1'b0;
            ifg_cnt   <= '0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            ready_ok <= 1'b1;
            case (state)
                ST_IDLE: begin
                    spd_q <= speed;
                    phase <= 1'b0;
                    if (accept) begin
                        state     <= ST_SEND;
                        phase     <= !gig;
                        frame_err <= tx_er;
                    end
                end
                ST_SEND: begin
                    if (eof) begin
                        frame_cnt <= frame_cnt + 1'b1;
                        if (frame_err) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                        frame_err <= 1'b0;
                        phase     <= 1'b0;
                        if (IFG_BYTES == 0) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_IFG;
                            ifg_cnt <= gig ? IFG_LD_1G : IFG_LD_SLOW;
                        end
                    end else if (accept) begin
                        if (tx_er) begin
                            frame_err <= 1'b1;
                        end
                        phase <= !gig;
                    end else begin
                        // second nibble slot of a 10/100 byte
                        phase <= 1'b0;
                    end
                end
                ST_IFG: begin
                    if (ifg_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        ifg_cnt <= ifg_cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // D-register stage: accepted byte lands here one edge after accept and
    // reaches the pins through the ODDR2 on the following edge.
    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            txd_d0 <= RGMII_IDLE;
            txd_d1 <= RGMII_IDLE;
            ctl_d0 <= 1'b0;
            ctl_d1 <= 1'b0;
            hi_q   <= 4'h0;
            er_q   <= 1'b0;
        end else if (accept) begin
            txd_d0 <= tx_data[3:0];
            txd_d1 <= gig ? tx_data[7:4] : tx_data[3:0];
            ctl_d0 <= 1'b1;
            ctl_d1 <= !tx_er;
            hi_q   <= tx_data[7:4];
            er_q   <= tx_er;
        end else if ((state == ST_SEND) && !gig && phase) begin
            // high nibble of a 10/100 byte, error flag held from the accept
            txd_d0 <= hi_q;
            txd_d1 <= hi_q;
            ctl_d0 <= 1'b1;
            ctl_d1 <= !er_q;
        end else begin
            txd_d0 <= RGMII_IDLE;
            txd_d1 <= RGMII_IDLE;
            ctl_d0 <= 1'b0;
            ctl_d1 <= 1'b0;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_txd
        rgmii_oddr_lane u_txd (
            .clk   (gmii_tx_clk),
            .rst_n (rst_n),
            .d0    (txd_d0[i]),
            .d1    (txd_d1[i]),
            .q     (rgmii_txd[i])
        );
    end

    rgmii_oddr_lane u_ctl (
        .clk   (gmii_tx_clk),
        .rst_n (rst_n),
        .d0    (ctl_d0),
        .d1    (ctl_d1),
        .q     (rgmii_tx_ctl)
    );

    if (TXC_ODDR != 0) begin : g_txc_oddr
        rgmii_oddr_lane u_txc (
            .clk   (gmii_tx_clk),
            .rst_n (rst_n),
            .d0    (1'b1),
            .d1    (1'b0),
            .q     (rgmii_txc)
        );
    end else begin : g_txc_direct
        assign rgmii_txc = gmii_tx_clk;
    end

endmodule
